// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM state type for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned DEPTH  = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Highest address the zero-fill visits for a given address width.
  function automatic int unsigned fill_last(input int unsigned aw);
    int unsigned span;
    span = 1 << aw;
    return (DEPTH < span) ? DEPTH - 1 : span - 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester A/B command ports, RAM port and status for ram_port_arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  import ram_arb_pkg::*;

  // Handshake: a command transfers in the cycle where x_valid and x_ready are
  // both 1; the requester holds valid and its command stable until then.
  // x_rvalid is a one-cycle pulse, x_rdata is only meaningful while it is high.
  logic          a_valid;
  logic          a_ready;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_valid;
  logic          b_ready;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          init_done;
  state_t        dbg_state;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout,
    output init_done, dbg_state
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout,
    input  init_done, dbg_state
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer names the loser after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  // ptr_q = 0 favours requester 0 (A), 1 favours requester 1 (B).
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o != 2'b00) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port registered RAM between requesters A and B, with optional zero-fill.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter bit          INIT_ZERO = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  ram_port_arbiter_if.slave   bus
);

  localparam logic [AW-1:0] FILL_LAST = AW'(fill_last(AW));
  localparam state_t        ST_RESET  = INIT_ZERO ? ST_INIT : ST_RUN;

  state_t        state_q;
  logic [AW-1:0] fill_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          rd1_vld_q;
  logic          rd1_port_q;
  logic          rd2_vld_q;
  logic          rd2_port_q;

  logic          in_init;
  logic          in_run;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          accept;
  logic          ptr_unused;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Gating with rst keeps every handshake and RAM strobe quiet while reset is held.
  assign in_init = (state_q == ST_INIT) && !rst;
  assign in_run  = (state_q == ST_RUN)  && !rst;

  assign req = {bus.b_valid, bus.a_valid} & {2{in_run}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .gnt_o (gnt),
    .ptr_o (ptr_unused)
  );

  assign accept  = |gnt;
  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  always_comb begin
    sel_we    = bus.a_we;
    sel_addr  = bus.a_addr;
    sel_wdata = bus.a_wdata;
    if (gnt[1]) begin
      sel_we    = bus.b_we;
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      fill_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rd1_vld_q  <= 1'b0;
      rd1_port_q <= 1'b0;
      rd2_vld_q  <= 1'b0;
      rd2_port_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          fill_q <= fill_q + AW'(1);
          if (fill_q == FILL_LAST) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase

      we_q <= accept && sel_we;
      if (accept) begin
        addr_q <= sel_addr;
        din_q  <= sel_wdata;
      end

      // Read return pipeline: issue to RAM at N+1, registered data back at N+2.
      rd1_vld_q  <= accept && !sel_we;
      rd1_port_q <= gnt[1];
      rd2_vld_q  <= rd1_vld_q;
      rd2_port_q <= rd1_port_q;
    end
  end

  assign bus.ram_we   = in_init ? 1'b1 : we_q;
  assign bus.ram_addr = in_init ? fill_q : addr_q;
  assign bus.ram_din  = in_init ? '0 : din_q;

  assign bus.a_rvalid = rd2_vld_q && !rd2_port_q;
  assign bus.b_rvalid = rd2_vld_q &&  rd2_port_q;
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;

  assign bus.init_done = in_run;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: zero-fill, table-driven traffic, alternation, reset drop.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .INIT_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ram_port_arbiter #(.AW(AW), .DW(DW), .INIT_ZERO(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // ---------------- clock / reset / RAM models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] mem2 [256];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  always @(posedge clk) begin
    if (bus2.ram_we) mem2[bus2.ram_addr] <= bus2.ram_din;
    bus2.ram_dout <= mem2[bus2.ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // exp_q entry: {port(1: 0=A,1=B), due cycle(16), data(32)}
  // wr_q entry:  {due cycle(16), addr(8), data(32)}
  logic [48:0] exp_q[$];
  logic [55:0] wr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [48:0] mon_e;
  logic [55:0] mon_w;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_q.delete();
    end else begin
      check("rvalid_exclusive", {63'd0, bus.a_rvalid & bus.b_rvalid}, 64'd0);
      if (exp_q.size() > 0 && exp_q[0][47:32] == cyc[15:0]) begin
        mon_e = exp_q.pop_front();
        check("rvalid_port", {62'd0, bus.a_rvalid, bus.b_rvalid}, mon_e[48] ? 64'd1 : 64'd2);
        check("rdata", {32'd0, mon_e[48] ? bus.b_rdata : bus.a_rdata}, {32'd0, mon_e[31:0]});
      end else begin
        check("no_rvalid", {62'd0, bus.a_rvalid, bus.b_rvalid}, 64'd0);
      end
      if (bus.init_done) begin
        if (wr_q.size() > 0 && wr_q[0][55:40] == cyc[15:0]) begin
          mon_w = wr_q.pop_front();
          check("ram_write", {23'd0, bus.ram_we, bus.ram_addr, bus.ram_din}, {23'd0, 1'b1, mon_w[39:0]});
        end else begin
          check("ram_idle_we", {63'd0, bus.ram_we}, 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic issue(input bit port, input bit we, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    if (!port) begin
      bus.a_valid = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_valid = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = port ? bus.b_ready : bus.a_ready;
      n++;
    end
    check("accepted", {63'd0, ok}, 64'd1);
    if (ok && !we) exp_q.push_back({port, 16'(cyc + 2), exp});
    if (ok && we)  wr_q.push_back({16'(cyc + 1), addr, wdata});
    @(posedge clk);
    #1;
    if (!port) bus.a_valid = 1'b0;
    else       bus.b_valid = 1'b0;
  endtask

  // Called at posedge+1 right after reset release; checks the whole zero-fill.
  task automatic fill_check();
    logic [7:0] ia;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ia = i[7:0];
      check("fill", {20'd0, bus.ram_we, bus.ram_addr, bus.ram_din, bus.a_ready, bus.b_ready, bus.init_done},
            {20'd0, 1'b1, ia, 32'd0, 2'b00, 1'b0});
    end
    @(negedge clk);
    check("init_done_after_fill", {62'd0, bus.init_done, bus.dbg_state == ST_RUN}, 64'd3);
  endtask

  task automatic reset_check();
    check("reset_outputs",
          {20'd0, bus.a_ready, bus.b_ready, bus.a_rvalid, bus.b_rvalid, bus.ram_we, bus.ram_addr, bus.ram_din, bus.init_done},
          64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        port;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 8'h11, 32'h0,        32'h00000000};
    vecs[3]  = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 8'h20, 32'h0,        32'h12345678};
    vecs[5]  = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 32'hCAFEF00D, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 8'hFF, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b1, 8'h10, 32'h0BADF00D, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 8'h10, 32'h0,        32'h0BADF00D};
    vecs[10] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'h0BADF00D};

    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus2.a_valid = 1'b1; bus2.a_we = 1'b1; bus2.a_addr = 8'h01; bus2.a_wdata = 32'h55AA55AA;
    bus2.b_valid = 1'b0; bus2.b_we = 1'b0; bus2.b_addr = '0; bus2.b_wdata = '0;

    repeat (3) @(negedge clk);
    reset_check();
    check("reset_state", {63'd0, bus.dbg_state == ST_INIT}, 64'd1);
    check("reset_dut2", {62'd0, bus2.init_done, bus2.a_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-fill with a pending A read of 0x05 that must be accepted right after fill.
    fork
      fill_check();
      issue(1'b0, 1'b0, 8'h05, 32'h0, 32'h00000000);
      begin
        @(negedge clk);
        check("dut2_run_at_once", {62'd0, bus2.init_done, bus2.a_ready}, 64'd3);
        @(posedge clk);
        #1;
        bus2.a_valid = 1'b0;
      end
    join

    for (int k = 0; k < 11; k++) begin
      issue(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp);
    end

    // Both requesters continuously valid: strict A,B alternation, one accept per cycle.
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h10;
    bus.b_valid = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h20;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("alternate_ready", {62'd0, bus.a_ready, bus.b_ready}, (k % 2 == 0) ? 64'd2 : 64'd1);
      if (k % 2 == 0) exp_q.push_back({1'b0, 16'(cyc + 2), 32'h0BADF00D});
      else            exp_q.push_back({1'b1, 16'(cyc + 2), 32'h12345678});
      @(posedge clk);
      #1;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset one cycle after a read accept: the read must vanish, fill restarts at 0.
    issue(1'b0, 1'b0, 8'h10, 32'h0, 32'h0BADF00D);
    rst = 1'b1;
    @(negedge clk);
    reset_check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_check();

    repeat (6) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AW, 8, RAM address width (256 words)
  DW, 32, RAM data width
  INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = skip fill
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous reset, active-high
  a_valid  in  1  requester A command valid
  a_ready  out  1  A command accepted this cycle when a_valid=1
  a_we  in  1  A: 1 = write, 0 = read
  a_addr  in  AW  A word address
  a_wdata  in  DW  A write data
  a_rvalid  out  1  A read data valid, one-cycle pulse
  a_rdata  out  DW  A read data, meaningful only while a_rvalid=1
  b_valid / b_ready / b_we / b_addr / b_wdata / b_rvalid / b_rdata  same as A, for requester B
  ram_we  out  1  RAM write enable
  ram_addr  out  AW  RAM address
  ram_din  out  DW  RAM write data
  ram_dout  in  DW  RAM registered read data, one-cycle latency, read-first
  init_done  out  1  high once zero-fill is complete (or immediately if INIT_ZERO=0)

Function
REQ-003 The block SHALL implement an FSM with states INIT and RUN, leaving reset in INIT when INIT_ZERO=1 and in RUN when INIT_ZERO=0.
REQ-004 In INIT: ram_we=1, ram_din=0, ram_addr = fill counter 0..255, one word per cycle; a_ready=b_ready=0.
REQ-005 The cycle after address 255 is written, the FSM SHALL enter RUN and assert init_done, which stays high until reset.
REQ-006 In RUN, a command SHALL be accepted in the cycle where x_valid and x_ready are both 1; at most one accept per cycle.
REQ-007 x_ready SHALL be combinational, and high only for the granted requester: sole valid requester wins; if both are valid, the requester named by the priority pointer wins.
REQ-008 After each accept, the priority pointer SHALL name the non-granted requester; the pointer resets to A.
REQ-009 Command accepted in cycle N SHALL appear registered on ram_we/ram_addr/ram_din in cycle N+1; ram_we=0 in RUN cycles without a registered accept.
REQ-010 For a read accepted in cycle N, x_rvalid SHALL pulse in cycle N+2 only on the issuing port, with x_rdata = ram_dout (combinational).
REQ-011 Writes SHALL produce no rvalid; a_rvalid and b_rvalid SHALL never be high in the same cycle.
REQ-012 Sustained throughput SHALL be one command per cycle; both valid continuously SHALL give strict A,B,A,B alternation.
REQ-013 A read accepted one cycle after a write to the same address SHALL return the newly written data.
REQ-014 Requesters hold valid and command stable until accepted; the block need not check this.

Reset
REQ-015 While rst=1: a_ready=b_ready=0, a_rvalid=b_rvalid=0, ram_we=0, ram_addr=0, ram_din=0, init_done=0, fill counter=0, pointer=A, in-flight tracking cleared.
REQ-016 Reset asserted mid-operation SHALL drop all in-flight commands with no rvalid emitted afterwards, and SHALL restart INIT from address 0 (INIT_ZERO=1).

Structure
REQ-017 Package ram_arb_pkg SHALL hold AW/DW defaults, DEPTH=256 and the INIT/RUN state enum.
REQ-018 Grant logic and priority pointer SHALL be a sub-module rr_arb2 (two requests in, one-hot grant out, pointer update on accept).

Verification
REQ-019 Reset released, INIT_ZERO=1 -> 256 consecutive ram_we=1 cycles, addr 0..255, din=0; init_done high on the next cycle; no ready during fill.
REQ-020 A writes 0xDEADBEEF to 0x10 at cycle N -> ram_we=1, ram_addr=0x10 at N+1; B then reads 0x10 -> b_rvalid two cycles after its accept with b_rdata=0xDEADBEEF; a_rvalid stays 0.
REQ-021 a_valid and b_valid held high for 8 reads -> accepts A,B,A,B,..., one per cycle, each rvalid on the correct port exactly 2 cycles after its accept.
REQ-022 Read 0x05 before any write after fill -> rdata=0x00000000.
REQ-023 rst pulsed one cycle after a read is accepted -> no rvalid ever appears for it; fill restarts at address 0.
REQ-024 INIT_ZERO=0 -> init_done=1 the first cycle after reset; a single a_valid is accepted that same cycle.
